// File: rtl/if_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage:
//   - default reset / interrupt / exception vectors
//   - IF_ID pipeline register field offsets ({PC+4, instruction})
//   - NOP encoding used for pipeline bubbles
//   - fetch FSM state encoding
//   - bubble() helper that builds a NOP IF_ID word for a resume address
// ----------------------------------------------------------------------------
package if_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] DEF_ILLOP_PC = 32'h8000_0004;
    localparam logic [31:0] DEF_XADR_PC  = 32'h8000_0008;

    localparam int IFID_INSTR_LSB = 0;
    localparam int IFID_INSTR_MSB = 31;
    localparam int IFID_PC4_LSB   = 32;
    localparam int IFID_PC4_MSB   = 63;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } if_state_e;

    // The NOP carries t+4 so that decode's (PC_plus4 - 4) equals the
    // address where execution resumes.
    function automatic logic [63:0] bubble(input logic [31:0] t);
        logic [63:0] b;
        b = '0;
        b[IFID_PC4_MSB:IFID_PC4_LSB]     = t + 32'd4;
        b[IFID_INSTR_MSB:IFID_INSTR_LSB] = NOP_INSTR;
        return b;
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// ----------------------------------------------------------------------------
// if_next_pc
// Combinational redirect priority mux for the fetch stage.
// Ports:
//   interrupt_i, exception_i  - trap requests (override a stall)
//   jr_i, j_i, z_i            - jump-register / jump / taken branch from decode
//   wr_en_i                   - PC_IF_ID_Write; 0 = load-use stall
//   branch_target_i, jump_target_i, jr_target_i - candidate targets
//   redirect_o                - a redirect is to be applied this cycle
//   target_o                  - selected redirect address
// Priority: interrupt > exception > JR > J > Z.
// ----------------------------------------------------------------------------
module if_next_pc
    import if_stage_pkg::*;
#(
    parameter logic [31:0] ILLOP_PC = DEF_ILLOP_PC,
    parameter logic [31:0] XADR_PC  = DEF_XADR_PC
) (
    input  logic        interrupt_i,
    input  logic        exception_i,
    input  logic        jr_i,
    input  logic        j_i,
    input  logic        z_i,
    input  logic        wr_en_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] jump_target_i,
    input  logic [31:0] jr_target_i,
    output logic        redirect_o,
    output logic [31:0] target_o
);

    // Control transfers from decode are ignored while stalled: decode holds
    // the same instruction and re-evaluates them next cycle. Traps are not.
    assign redirect_o = interrupt_i | exception_i | (wr_en_i & (jr_i | j_i | z_i));

    always_comb begin
        target_o = branch_target_i;
        if (interrupt_i)      target_o = ILLOP_PC;
        else if (exception_i) target_o = XADR_PC;
        else if (jr_i)        target_o = jr_target_i;
        else if (j_i)         target_o = jump_target_i;
    end

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage feeding decode. Owns the PC and the fetch request
// to a variable-latency instruction memory, and produces IF_ID.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   Z, J, JR                - branch taken / jump / jump register (decode)
//   PC_IF_ID_Write          - 0 = load-use stall (hold PC and IF_ID)
//   branch_target, jump_target, jr_target - redirect targets
//   interrupt, exception    - trap requests (vectors ILLOP_PC / XADR_PC)
//   imem_req, imem_addr     - fetch request and address
//   imem_ready, imem_rdata  - fetch completion and data (zero-wait allowed)
//   if_pc                   - current PC register (debug)
//   IF_ID                   - {PC+4, instruction}
// FSM: RUN fetches normally; DRAIN waits out a request that was in flight
// when a redirect arrived, discarding its data, then resumes at redir_q.
// ----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] ILLOP_PC = DEF_ILLOP_PC,
    parameter logic [31:0] XADR_PC  = DEF_XADR_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Z,
    input  logic        J,
    input  logic        JR,
    input  logic        PC_IF_ID_Write,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic        interrupt,
    input  logic        exception,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [63:0] IF_ID
);

    if_state_e   state_q;
    logic [31:0] pc_q;
    logic [63:0] if_id_q;
    logic [31:0] redir_q;
    logic [31:0] redir_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    if_next_pc #(
        .ILLOP_PC (ILLOP_PC),
        .XADR_PC  (XADR_PC)
    ) u_next_pc (
        .interrupt_i     (interrupt),
        .exception_i     (exception),
        .jr_i            (JR),
        .j_i             (J),
        .z_i             (Z),
        .wr_en_i         (PC_IF_ID_Write),
        .branch_target_i (branch_target),
        .jump_target_i   (jump_target),
        .jr_target_i     (jr_target),
        .redirect_o      (redirect),
        .target_o        (target)
    );

    assign pc_plus4 = pc_q + 32'd4;

    // While draining, a newly arriving trap replaces the pending target
    // even during a stall; branch/jump inputs are not considered here.
    always_comb begin
        redir_d = redir_q;
        if (interrupt)      redir_d = ILLOP_PC;
        else if (exception) redir_d = XADR_PC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            if_id_q <= '0;
            redir_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (redirect) begin
                        if_id_q <= bubble(target);
                        if (imem_ready) begin
                            pc_q <= target;
                        end else begin
                            // pc_q held so imem_addr stays stable until the
                            // outstanding request completes.
                            redir_q <= target;
                            state_q <= ST_DRAIN;
                        end
                    end else if (!PC_IF_ID_Write) begin
                        // Stall: any returned word is dropped and refetched.
                        if_id_q <= if_id_q;
                    end else if (imem_ready) begin
                        if_id_q <= {pc_plus4, imem_rdata};
                        pc_q    <= pc_plus4;
                    end else begin
                        if_id_q <= bubble(pc_q);
                    end
                end
                ST_DRAIN: begin
                    redir_q <= redir_d;
                    if (PC_IF_ID_Write) begin
                        if_id_q <= bubble(redir_d);
                    end
                    if (imem_ready) begin
                        pc_q    <= redir_d;
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign imem_req  = rst_n;
    assign imem_addr = pc_q;
    assign if_pc     = pc_q;
    assign IF_ID     = if_id_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] RST_V = 32'h8000_0000;
    localparam logic [31:0] IRQ_V = 32'h8000_0004;
    localparam logic [31:0] EXC_V = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Z = 0, J = 0, JR = 0, PC_IF_ID_Write = 1;
    logic [31:0] branch_target = 0, jump_target = 0, jr_target = 0;
    logic        interrupt = 0, exception = 0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 0;
    logic [31:0] imem_rdata = 0;
    logic [31:0] if_pc;
    logic [63:0] IF_ID;

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .Z(Z), .J(J), .JR(JR),
        .PC_IF_ID_Write(PC_IF_ID_Write),
        .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
        .interrupt(interrupt), .exception(exception),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_pc(if_pc), .IF_ID(IF_ID)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          z, j, jr, wr, irq, exc, rdy;
        logic [31:0] rdata, bt, jt, jrt;
        logic [31:0] e_addr, e_pc;
        logic [63:0] e_ifid;
    } vec_t;

    // Reference model: architectural view of the fetch stage.
    typedef struct {
        logic [31:0] pc;
        logic [63:0] ifid;
        bit          waiting;   // an abandoned request is still outstanding
        logic [31:0] resume;    // where fetch continues once it completes
    } model_t;

    model_t m;
    int     n_err = 0;
    int     n_chk = 0;
    vec_t   tbl[$];

    function automatic vec_t mk(bit z, bit j, bit jr, bit wr, bit irq, bit exc, bit rdy,
                                logic [31:0] rdata, logic [31:0] bt, logic [31:0] jt,
                                logic [31:0] jrt, logic [31:0] e_addr, logic [31:0] e_pc,
                                logic [63:0] e_ifid);
        vec_t v;
        v.z = z; v.j = j; v.jr = jr; v.wr = wr; v.irq = irq; v.exc = exc; v.rdy = rdy;
        v.rdata = rdata; v.bt = bt; v.jt = jt; v.jrt = jrt;
        v.e_addr = e_addr; v.e_pc = e_pc; v.e_ifid = e_ifid;
        return v;
    endfunction

    function automatic logic [63:0] nop_for(logic [31:0] t);
        logic [31:0] p4;
        p4 = t + 32'd4;
        return {p4, 32'h0};
    endfunction

    function automatic model_t model_next(model_t s, vec_t v);
        model_t n;
        logic [31:0] tgt;
        bit          take;
        n = s;
        if (!s.waiting) begin
            take = v.irq || v.exc || (v.wr && (v.jr || v.j || v.z));
            if (v.irq)      tgt = IRQ_V;
            else if (v.exc) tgt = EXC_V;
            else if (v.jr)  tgt = v.jrt;
            else if (v.j)   tgt = v.jt;
            else            tgt = v.bt;
            if (take) begin
                n.ifid = nop_for(tgt);
                if (v.rdy) n.pc = tgt;
                else begin n.waiting = 1; n.resume = tgt; end
            end else if (v.wr) begin
                if (v.rdy) begin
                    n.ifid = {s.pc + 32'd4, v.rdata};
                    n.pc   = s.pc + 32'd4;
                end else begin
                    n.ifid = nop_for(s.pc);
                end
            end
        end else begin
            if (v.irq)      n.resume = IRQ_V;
            else if (v.exc) n.resume = EXC_V;
            if (v.wr) n.ifid = nop_for(n.resume);
            if (v.rdy) begin
                n.pc = n.resume;
                n.waiting = 0;
            end
        end
        return n;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at posedge+1: apply inputs, check the request, clock, check state.
    task automatic step(vec_t v, bit use_tbl, string tag);
        logic [31:0] ea, ep;
        logic [63:0] ei;
        Z = v.z; J = v.j; JR = v.jr; PC_IF_ID_Write = v.wr;
        interrupt = v.irq; exception = v.exc; imem_ready = v.rdy;
        imem_rdata = v.rdata; branch_target = v.bt; jump_target = v.jt; jr_target = v.jrt;
        #1;
        ea = use_tbl ? v.e_addr : m.pc;
        chk({tag, " imem_addr"}, {32'h0, imem_addr}, {32'h0, ea});
        chk({tag, " imem_req"}, {63'h0, imem_req}, 64'h1);
        m = model_next(m, v);
        ep = use_tbl ? v.e_pc : m.pc;
        ei = use_tbl ? v.e_ifid : m.ifid;
        @(posedge clk);
        #1;
        chk({tag, " if_pc"}, {32'h0, if_pc}, {32'h0, ep});
        chk({tag, " IF_ID"}, IF_ID, ei);
    endtask

    initial begin
        vec_t v;
        m.pc = RST_V; m.ifid = '0; m.waiting = 0; m.resume = '0;

        // Directed table: {z j jr wr irq exc rdy, rdata, bt jt jrt, addr, pc', IF_ID'}
        // 1. zero-wait sequential fetch
        tbl.push_back(mk(0,0,0,1,0,0,1, 32'hA000_0000, 0,0,0, 32'h8000_0000, 32'h8000_0004, 64'h8000_0004_A000_0000));
        tbl.push_back(mk(0,0,0,1,0,0,1, 32'hA000_0001, 0,0,0, 32'h8000_0004, 32'h8000_0008, 64'h8000_0008_A000_0001));
        tbl.push_back(mk(0,0,0,1,0,0,1, 32'hA000_0002, 0,0,0, 32'h8000_0008, 32'h8000_000C, 64'h8000_000C_A000_0002));
        // 2. taken branch with ready: one bubble, fetched word dropped
        tbl.push_back(mk(1,0,0,1,0,0,1, 32'hDEAD_BEEF, 32'h8000_0100,0,0, 32'h8000_000C, 32'h8000_0100, 64'h8000_0104_0000_0000));
        tbl.push_back(mk(0,0,0,1,0,0,1, 32'hB000_0000, 0,0,0, 32'h8000_0100, 32'h8000_0104, 64'h8000_0104_B000_0000));
        // 3. stall with J asserted: J ignored, state held, same address refetched
        tbl.push_back(mk(0,1,0,0,0,0,1, 32'hCCCC_CCCC, 0,32'h8000_0300,0, 32'h8000_0104, 32'h8000_0104, 64'h8000_0104_B000_0000));
        tbl.push_back(mk(0,1,0,0,0,0,1, 32'hCCCC_CCCD, 0,32'h8000_0300,0, 32'h8000_0104, 32'h8000_0104, 64'h8000_0104_B000_0000));
        tbl.push_back(mk(0,0,0,1,0,0,1, 32'hB000_0001, 0,0,0, 32'h8000_0104, 32'h8000_0108, 64'h8000_0108_B000_0001));
        // 4. JR while memory waits: drain with bubbles, then resume at target
        tbl.push_back(mk(0,0,1,1,0,0,0, 32'h1111_1111, 0,0,32'h8000_0200, 32'h8000_0108, 32'h8000_0108, 64'h8000_0204_0000_0000));
        tbl.push_back(mk(0,0,1,1,0,0,0, 32'h1111_1112, 0,0,32'h8000_0200, 32'h8000_0108, 32'h8000_0108, 64'h8000_0204_0000_0000));
        tbl.push_back(mk(0,0,1,1,0,0,0, 32'h1111_1113, 0,0,32'h8000_0200, 32'h8000_0108, 32'h8000_0108, 64'h8000_0204_0000_0000));
        tbl.push_back(mk(0,0,0,1,0,0,1, 32'h1111_1114, 0,0,0, 32'h8000_0108, 32'h8000_0200, 64'h8000_0204_0000_0000));
        tbl.push_back(mk(0,0,0,1,0,0,1, 32'hC000_0000, 0,0,0, 32'h8000_0200, 32'h8000_0204, 64'h8000_0204_C000_0000));
        // 5. interrupt and exception together during a stall: interrupt wins
        tbl.push_back(mk(0,0,0,0,1,1,1, 32'h2222_2222, 0,0,0, 32'h8000_0204, 32'h8000_0004, 64'h8000_0008_0000_0000));
        tbl.push_back(mk(0,0,0,1,0,0,1, 32'hD000_0000, 0,0,0, 32'h8000_0004, 32'h8000_0008, 64'h8000_0008_D000_0000));
        // PC+4 wrap at the top of the address space
        tbl.push_back(mk(0,1,0,1,0,0,1, 32'h3333_3333, 0,32'hFFFF_FFFC,0, 32'h8000_0008, 32'hFFFF_FFFC, 64'h0000_0000_0000_0000));
        tbl.push_back(mk(0,0,0,1,0,0,1, 32'hE000_0000, 0,0,0, 32'hFFFF_FFFC, 32'h0000_0000, 64'h0000_0000_E000_0000));
        // exception arriving mid-drain while stalled: replaces target, IF_ID held
        tbl.push_back(mk(0,0,1,1,0,0,0, 32'h4444_4444, 0,0,32'h8000_0400, 32'h0000_0000, 32'h0000_0000, 64'h8000_0404_0000_0000));
        tbl.push_back(mk(0,0,0,0,0,1,0, 32'h4444_4445, 0,0,0, 32'h0000_0000, 32'h0000_0000, 64'h8000_0404_0000_0000));
        tbl.push_back(mk(0,0,0,1,0,0,1, 32'h4444_4446, 0,0,0, 32'h0000_0000, 32'h8000_0008, 64'h8000_000C_0000_0000));
        tbl.push_back(mk(0,0,0,1,0,0,1, 32'hF000_0000, 0,0,0, 32'h8000_0008, 32'h8000_000C, 64'h8000_000C_F000_0000));
        // plain memory wait state, then completion
        tbl.push_back(mk(0,0,0,1,0,0,0, 32'h5555_5555, 0,0,0, 32'h8000_000C, 32'h8000_000C, 64'h8000_0010_0000_0000));
        tbl.push_back(mk(0,0,0,1,0,0,1, 32'hF000_0001, 0,0,0, 32'h8000_000C, 32'h8000_0010, 64'h8000_0010_F000_0001));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset if_pc", {32'h0, if_pc}, {32'h0, RST_V});
        chk("reset IF_ID", IF_ID, 64'h0);
        chk("reset imem_req", {63'h0, imem_req}, 64'h0);
        rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

        // Randomized run against the model
        for (int c = 0; c < 400; c++) begin
            v.z   = ($urandom_range(0, 5) == 0);
            v.j   = ($urandom_range(0, 7) == 0);
            v.jr  = ($urandom_range(0, 7) == 0);
            v.wr  = ($urandom_range(0, 4) != 0);
            v.irq = ($urandom_range(0, 19) == 0);
            v.exc = ($urandom_range(0, 19) == 0);
            v.rdy = ($urandom_range(0, 2) != 0);
            v.rdata = $urandom;
            v.bt  = $urandom & 32'hFFFF_FFFC;
            v.jt  = $urandom & 32'hFFFF_FFFC;
            v.jrt = $urandom & 32'hFFFF_FFFC;
            v.e_addr = '0; v.e_pc = '0; v.e_ifid = '0;
            step(v, 1'b0, $sformatf("rnd%0d", c));
        end

        // 6. asynchronous reset while draining
        v = mk(0,0,1,1,0,0,0, 32'h6666_6666, 0,0,32'h8000_0500, 0,0,0);
        step(v, 1'b0, "pre-drain");
        chk("in drain", {63'h0, m.waiting}, 64'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst if_pc", {32'h0, if_pc}, {32'h0, RST_V});
        chk("async rst IF_ID", IF_ID, 64'h0);
        chk("async rst imem_req", {63'h0, imem_req}, 64'h0);
        m.pc = RST_V; m.ifid = '0; m.waiting = 0; m.resume = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v = mk(0,0,0,1,0,0,1, 32'h7777_7777, 0,0,0, 32'h8000_0000, 32'h8000_0004, 64'h8000_0004_7777_7777);
        step(v, 1'b1, "post-reset");
        v = mk(0,0,0,1,0,0,1, 32'h7777_7778, 0,0,0, 32'h8000_0004, 32'h8000_0008, 64'h8000_0008_7777_7778);
        step(v, 1'b1, "post-reset2");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
